// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and controller state type shared by the muldiv unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between an issuing pipeline and muldiv_unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration (shift-add multiply / restoring divide).
// Divide path present only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic             i_div,
`endif
    input  logic [WIDTH-1:0] i_upper,
    input  logic [WIDTH-1:0] i_lower,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_upper,
    output logic [WIDTH-1:0] o_lower
);
    logic [WIDTH:0] w_sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
`endif

    always_comb begin
        // Multiply: conditionally add multiplicand, then shift {carry,upper,lower} right
        w_sum   = {1'b0, i_upper} + (i_lower[0] ? {1'b0, i_opnd} : '0);
        o_upper = w_sum[WIDTH:1];
        o_lower = {w_sum[0], i_lower[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Remainder stays below the divisor, so the difference fits in WIDTH bits
        w_shift = {i_upper, i_lower[WIDTH-1]};
        w_diff  = w_shift[WIDTH-1:0] - i_opnd;
        if (i_div) begin
            if (w_shift >= {1'b0, i_opnd}) begin
                o_upper = w_diff;
                o_lower = {i_lower[WIDTH-2:0], 1'b1};
            end else begin
                o_upper = w_shift[WIDTH-1:0];
                o_lower = {i_lower[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit with MTHI/MTLO writes.
// Build option: define MULDIV_DIV_EN to include the restoring divider.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    import muldiv_pkg::*;

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_upper, r_lower, r_opnd;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_neg_q, r_done, r_dbz;
    logic               w_signed, w_a_neg, w_neg_q;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_upper, w_lower;
    logic [2*WIDTH-1:0] w_prod;
`ifdef MULDIV_DIV_EN
    logic               r_div, r_neg_r;
    logic [WIDTH-1:0]   w_quo, w_rem;
`endif

    always_comb begin
        w_signed = op_is_signed(bus.op);
        w_a_neg  = w_signed & bus.a[WIDTH-1];
        w_neg_q  = w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        w_a_mag  = w_a_neg ? -bus.a : bus.a;
        w_b_mag  = (w_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;
        w_prod   = {w_upper, w_lower};
        if (r_neg_q) w_prod = -w_prod;
`ifdef MULDIV_DIV_EN
        w_quo = r_neg_q ? -w_lower : w_lower;
        w_rem = r_neg_r ? -w_upper : w_upper;
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
        .i_div   (r_div),
`endif
        .i_upper (r_upper),
        .i_lower (r_lower),
        .i_opnd  (r_opnd),
        .o_upper (w_upper),
        .o_lower (w_lower)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_upper <= '0;
            r_lower <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_div   <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else if (bus.abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MTHI: r_hi <= bus.a;
                            OP_MTLO: r_lo <= bus.a;
                            OP_MULTU, OP_MULT: begin
                                r_upper <= '0;
                                r_lower <= w_b_mag;
                                r_opnd  <= w_a_mag;
                                r_neg_q <= w_neg_q;
                                r_cnt   <= CNT_INIT;
                                r_state <= S_CALC;
`ifdef MULDIV_DIV_EN
                                r_div   <= 1'b0;
`endif
                            end
                            OP_DIVU, OP_DIV: begin
`ifdef MULDIV_DIV_EN
                                if (bus.b == '0) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                    r_dbz   <= 1'b1;
                                end else begin
                                    r_upper <= '0;
                                    r_lower <= w_a_mag;
                                    r_opnd  <= w_b_mag;
                                    r_neg_q <= w_neg_q;
                                    r_neg_r <= w_a_neg;
                                    r_div   <= 1'b1;
                                    r_cnt   <= CNT_INIT;
                                    r_state <= S_CALC;
                                end
`else
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    r_upper <= w_upper;
                    r_lower <= w_lower;
                    r_cnt   <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
`ifdef MULDIV_DIV_EN
                        if (r_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
`else
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
`endif
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_dbz   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table, randomized ops against an arithmetic model, and
// hand sequences for abort, start-while-busy and asynchronous reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dbz;
        int          lat;
    } vec_t;

`ifdef MULDIV_DIV_EN
    localparam logic [31:0] HI4 = 32'h0000_0000;
    localparam logic [31:0] LO4 = 32'h8000_0000;
`else
    localparam logic [31:0] HI4 = 32'hFFFF_FFFF;
    localparam logic [31:0] LO4 = 32'hFFFF_FFF1;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    muldiv_if #(.WIDTH(32)) mif ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(mif.slave));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Architectural result of one request, from plain arithmetic
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo,
                                  output bit dbz, output int lat);
        logic [63:0] p;
        longint      sa, sb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        lat = 0;
        case (op)
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; lat = 33; end
            OP_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; lat = 33; end
            OP_DIVU, OP_DIV: begin
                lat = 1;
`ifdef MULDIV_DIV_EN
                if (b == '0) dbz = 1'b1;
                else begin
                    lat = 33;
                    if (op == OP_DIVU) begin
                        lo = a / b;
                        hi = a % b;
                    end else begin
                        p = sa / sb; lo = p[31:0];
                        p = sa % sb; hi = p[31:0];
                    end
                end
`endif
            end
            OP_MTHI: hi = a;
            OP_MTLO: lo = a;
            default: ;
        endcase
    endfunction

    task automatic apply_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                               input bit edbz, input int elat);
        int lat, busy_n, dbz_seen;
        mif.op = op; mif.a = a; mif.b = b; mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        lat = 0; busy_n = 0; dbz_seen = 0;
        for (int c = 1; c <= elat + 5; c++) begin
            busy_n += int'(mif.busy);
            if (mif.done) begin
                lat = c;
                dbz_seen = int'(mif.div_by_zero);
                break;
            end
            tick();
        end
        chki({tag, " latency"}, lat, elat);
        chk32({tag, " hi"}, mif.hi, eh);
        chk32({tag, " lo"}, mif.lo, el);
        chki({tag, " div_by_zero"}, dbz_seen, int'(edbz));
        chki({tag, " busy cycles"}, busy_n, elat);
        tick();
        chki({tag, " done low after"}, int'(mif.done), 0);
        chki({tag, " idle after"}, int'(mif.busy), 0);
    endtask

    initial begin
        vec_t        vt[10];
        logic [31:0] m_hi, m_lo, ra, rb;
        logic [2:0]  rop;
        bit          edbz;
        int          elat, lat, done_seen;

        vt[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vt[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33};
`ifdef MULDIV_DIV_EN
        vt[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vt[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, HI4,           LO4,           1'b0, 33};
        vt[4] = '{OP_DIVU,  32'd7,         32'd0,         HI4,           LO4,           1'b1, 1};
`else
        vt[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         HI4,           LO4,           1'b0, 1};
        vt[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, HI4,           LO4,           1'b0, 1};
        vt[4] = '{OP_DIVU,  32'd7,         32'd0,         HI4,           LO4,           1'b0, 1};
`endif
        vt[5] = '{OP_MTHI,  32'h0000_1234, 32'h0000_FFFF, 32'h0000_1234, LO4,           1'b0, 0};
        vt[6] = '{OP_MTLO,  32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 1'b0, 0};
        vt[7] = '{OP_MULTU, 32'd6,         32'd7,         32'h0000_0000, 32'd42,        1'b0, 33};
        vt[8] = '{3'b110,   32'h0000_9999, 32'd1,         32'h0000_0000, 32'd42,        1'b0, 0};
        vt[9] = '{3'b111,   32'h0000_7777, 32'd0,         32'h0000_0000, 32'd42,        1'b0, 0};

        reset = 1'b1;
        mif.start = 1'b0; mif.abort = 1'b0; mif.op = '0; mif.a = '0; mif.b = '0;
        #1 reset = 1'b0;
        #3;
        chk32("reset hi", mif.hi, 32'd0);
        chk32("reset lo", mif.lo, 32'd0);
        chki("reset busy", int'(mif.busy), 0);
        chki("reset done", int'(mif.done), 0);
        chki("reset div_by_zero", int'(mif.div_by_zero), 0);
        #8 reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++)
            apply_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                        vt[i].hi, vt[i].lo, vt[i].dbz, vt[i].lat);

        m_hi = 32'd0;
        m_lo = 32'd42;
        for (int i = 0; i < 50; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            model(rop, ra, rb, m_hi, m_lo, edbz, elat);
            apply_check($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, m_hi, m_lo, edbz, elat);
        end

        // Abort mid-multiply; an MTHI issued while busy must be ignored
        apply_check("pre mthi", OP_MTHI, 32'h1111, '0, 32'h1111, m_lo, 1'b0, 0);
        apply_check("pre mtlo", OP_MTLO, 32'h2222, '0, 32'h1111, 32'h2222, 1'b0, 0);
        mif.op = OP_MULTU; mif.a = 32'd7; mif.b = 32'd9; mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        done_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mif.done) done_seen = 1;
            if (c == 10) chki("abort busy c10", int'(mif.busy), 1);
            if (c == 11) chki("abort idle c11", int'(mif.busy), 0);
            mif.start = (c == 5);
            if (c == 5) begin mif.op = OP_MTHI; mif.a = 32'hDEAD; end
            mif.abort = (c == 10);
            tick();
        end
        chki("abort no done", done_seen, 0);
        chk32("abort hi held", mif.hi, 32'h1111);
        chk32("abort lo held", mif.lo, 32'h2222);

        mif.abort = 1'b1; mif.start = 1'b1; mif.op = OP_MTHI; mif.a = 32'hBEEF;
        tick();
        chk32("abort+mthi dropped", mif.hi, 32'h1111);
        mif.op = OP_MULTU; mif.a = 32'd3; mif.b = 32'd3;
        tick();
        chki("abort+multu dropped", int'(mif.busy), 0);
        mif.abort = 1'b0; mif.start = 1'b0;
        tick();

        // New operands offered mid-operation must not disturb the latched ones
        mif.op = OP_MULTU; mif.a = 32'h0001_0003; mif.b = 32'd5; mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mif.done && lat == 0) lat = c;
            mif.start = (c == 5);
            if (c == 5) begin mif.a = 32'hFFFF_FFFF; mif.b = 32'hFFFF_FFFF; end
            tick();
        end
        chki("busy-start latency", lat, 33);
        chk32("busy-start hi", mif.hi, 32'h0);
        chk32("busy-start lo", mif.lo, 32'h0005_000F);
        chki("busy-start idle", int'(mif.busy), 0);

        // Asynchronous reset in the middle of a long operation
        apply_check("pre-rst mthi", OP_MTHI, 32'hA5A5, '0, 32'hA5A5, 32'h0005_000F, 1'b0, 0);
        apply_check("pre-rst mtlo", OP_MTLO, 32'h5A5A, '0, 32'hA5A5, 32'h5A5A, 1'b0, 0);
`ifdef MULDIV_DIV_EN
        mif.op = OP_DIVU;
`else
        mif.op = OP_MULTU;
`endif
        mif.a = 32'd1000; mif.b = 32'd3; mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        chki("mid-op busy c15", int'(mif.busy), 1);
        #2 reset = 1'b0;
        #1;
        chk32("async rst hi", mif.hi, 32'd0);
        chk32("async rst lo", mif.lo, 32'd0);
        chki("async rst busy", int'(mif.busy), 0);
        chki("async rst done", int'(mif.done), 0);
        #1 reset = 1'b1;
        apply_check("post-rst multu", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
